// File: rtl/uart_link_ctrl.sv
// Sequencer between the UART FIFOs and the tx/rx cores: drains the TX FIFO into the
// transmitter, moves received bytes into the RX FIFO, and keeps status counters.
module uart_link_ctrl #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter bit          DROP_ON_FULL = 1'b1
) (
  input  logic             i_sys_clk,
  input  logic             i_arst_n,
  input  logic             i_srst,
  input  logic             i_tx_en_cfg,
  input  logic             i_rx_en_cfg,
  input  logic             i_clr_cnt,
  input  logic             i_tx_fifo_empty,
  input  logic             i_tx_empty,
  input  logic             i_rx_empty,
  input  logic             i_rx_frame_err,
  input  logic             i_rx_fifo_full,
  output logic             o_tx_fifo_pop,
  output logic             o_ld_tx_data,
  output logic             o_tx_en,
  output logic             o_rx_en,
  output logic             o_uld_rx_data,
  output logic             o_rx_fifo_push,
  output logic             o_tx_busy,
  output logic             o_tx_timeout,
  output logic [CNT_W-1:0] o_tx_byte_cnt,
  output logic [CNT_W-1:0] o_rx_byte_cnt,
  output logic [CNT_W-1:0] o_rx_drop_cnt,
  output logic [CNT_W-1:0] o_frame_err_cnt
);

  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {TX_IDLE, TX_POP, TX_DATA, TX_LOAD, TX_WAIT, TX_DRAIN} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_PUSH, RX_UNLOAD, RX_SETTLE} rx_state_e;

  tx_state_e          tx_state_q, tx_state_d;
  rx_state_e          rx_state_q, rx_state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               tx_en_q, tx_en_d;
  logic               rx_en_q, rx_en_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   fe_cnt_q, fe_cnt_d;
  logic               timeout_set, fe_inc, drop_inc;

  // State register
  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      wait_cnt_q <= '0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      timeout_q  <= 1'b0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
      fe_cnt_q   <= '0;
    end else if (i_srst) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      wait_cnt_q <= '0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      timeout_q  <= 1'b0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
      fe_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      wait_cnt_q <= wait_cnt_d;
      tx_en_q    <= tx_en_d;
      rx_en_q    <= rx_en_d;
      timeout_q  <= timeout_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fe_cnt_q   <= fe_cnt_d;
    end
  end

  // Next-state logic for both FSMs and the counters
  always_comb begin
    tx_state_d  = tx_state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_set = 1'b0;
    unique case (tx_state_q)
      TX_IDLE:  if (i_tx_en_cfg && !i_tx_fifo_empty && i_tx_empty) tx_state_d = TX_POP;
      TX_POP:   tx_state_d = TX_DATA;
      TX_DATA:  tx_state_d = TX_LOAD;
      TX_LOAD: begin
        tx_state_d = TX_WAIT;
        wait_cnt_d = '0;
      end
      TX_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (!i_tx_empty) begin
          tx_state_d = TX_DRAIN;
        end else if (wait_cnt_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
          tx_state_d  = TX_IDLE;
          timeout_set = 1'b1;
        end
      end
      TX_DRAIN: if (i_tx_empty) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase

    rx_state_d = rx_state_q;
    fe_inc     = 1'b0;
    drop_inc   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        // Frame error wins over the full check; without drop policy the byte waits in the receiver.
        if (i_rx_en_cfg && !i_rx_empty) begin
          if (i_rx_frame_err) begin
            fe_inc     = 1'b1;
            rx_state_d = RX_UNLOAD;
          end else if (i_rx_fifo_full) begin
            if (DROP_ON_FULL) begin
              drop_inc   = 1'b1;
              rx_state_d = RX_UNLOAD;
            end
          end else begin
            rx_state_d = RX_PUSH;
          end
        end
      end
      RX_PUSH:   rx_state_d = RX_UNLOAD;
      RX_UNLOAD: rx_state_d = RX_SETTLE;
      RX_SETTLE: if (i_rx_empty) rx_state_d = RX_IDLE;
      default:   rx_state_d = RX_IDLE;
    endcase

    tx_en_d = i_tx_en_cfg || (tx_state_q != TX_IDLE);
    rx_en_d = i_rx_en_cfg;

    timeout_d  = timeout_q | timeout_set;
    tx_cnt_d   = (tx_state_q == TX_LOAD) ? tx_cnt_q + CNT_W'(1) : tx_cnt_q;
    rx_cnt_d   = (rx_state_q == RX_PUSH) ? rx_cnt_q + CNT_W'(1) : rx_cnt_q;
    drop_cnt_d = (drop_inc && drop_cnt_q != '1) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    fe_cnt_d   = (fe_inc && fe_cnt_q != '1) ? fe_cnt_q + CNT_W'(1) : fe_cnt_q;
    if (i_clr_cnt) begin
      timeout_d  = 1'b0;
      tx_cnt_d   = '0;
      rx_cnt_d   = '0;
      drop_cnt_d = '0;
      fe_cnt_d   = '0;
    end
  end

  // Moore outputs
  always_comb begin
    o_tx_fifo_pop   = (tx_state_q == TX_POP);
    o_ld_tx_data    = (tx_state_q == TX_LOAD);
    o_tx_busy       = (tx_state_q != TX_IDLE);
    o_rx_fifo_push  = (rx_state_q == RX_PUSH);
    o_uld_rx_data   = (rx_state_q == RX_UNLOAD);
    o_tx_en         = tx_en_q;
    o_rx_en         = rx_en_q;
    o_tx_timeout    = timeout_q;
    o_tx_byte_cnt   = tx_cnt_q;
    o_rx_byte_cnt   = rx_cnt_q;
    o_rx_drop_cnt   = drop_cnt_q;
    o_frame_err_cnt = fe_cnt_q;
  end

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl: small transmitter/receiver models and hand-computed expectations.
module tb_uart_link_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n, srst, tx_en_cfg, rx_en_cfg, clr;
  logic tx_fifo_empty, tx_empty, rx_empty, ferr, full;
  logic pop, ld, tx_en, rx_en, uld, push, busy, tout;
  logic [7:0] tx_cnt, rx_cnt, drop_cnt, fe_cnt;

  logic b_rx_empty, b_ferr, b_full;
  logic b_pop, b_ld, b_tx_en, b_rx_en, b_uld, b_push, b_busy, b_tout;
  logic [7:0] b_tx_cnt, b_rx_cnt, b_drop_cnt, b_fe_cnt;

  logic [39:0] all_out;
  assign all_out = {pop, ld, tx_en, rx_en, uld, push, busy, tout, tx_cnt, rx_cnt, drop_cnt, fe_cnt};

  uart_link_ctrl #(.CNT_W(8), .ACK_TIMEOUT(16), .DROP_ON_FULL(1'b1)) dut (
    .i_sys_clk(clk), .i_arst_n(arst_n), .i_srst(srst), .i_tx_en_cfg(tx_en_cfg),
    .i_rx_en_cfg(rx_en_cfg), .i_clr_cnt(clr), .i_tx_fifo_empty(tx_fifo_empty),
    .i_tx_empty(tx_empty), .i_rx_empty(rx_empty), .i_rx_frame_err(ferr),
    .i_rx_fifo_full(full), .o_tx_fifo_pop(pop), .o_ld_tx_data(ld), .o_tx_en(tx_en),
    .o_rx_en(rx_en), .o_uld_rx_data(uld), .o_rx_fifo_push(push), .o_tx_busy(busy),
    .o_tx_timeout(tout), .o_tx_byte_cnt(tx_cnt), .o_rx_byte_cnt(rx_cnt),
    .o_rx_drop_cnt(drop_cnt), .o_frame_err_cnt(fe_cnt)
  );

  // Back-pressure variant: shares clock/reset/config, has its own receiver-side inputs.
  uart_link_ctrl #(.CNT_W(8), .ACK_TIMEOUT(16), .DROP_ON_FULL(1'b0)) dut_bp (
    .i_sys_clk(clk), .i_arst_n(arst_n), .i_srst(srst), .i_tx_en_cfg(1'b0),
    .i_rx_en_cfg(rx_en_cfg), .i_clr_cnt(clr), .i_tx_fifo_empty(1'b1),
    .i_tx_empty(1'b1), .i_rx_empty(b_rx_empty), .i_rx_frame_err(b_ferr),
    .i_rx_fifo_full(b_full), .o_tx_fifo_pop(b_pop), .o_ld_tx_data(b_ld), .o_tx_en(b_tx_en),
    .o_rx_en(b_rx_en), .o_uld_rx_data(b_uld), .o_rx_fifo_push(b_push), .o_tx_busy(b_busy),
    .o_tx_timeout(b_tout), .o_tx_byte_cnt(b_tx_cnt), .o_rx_byte_cnt(b_rx_cnt),
    .o_rx_drop_cnt(b_drop_cnt), .o_frame_err_cnt(b_fe_cnt)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receiver model: presents n bytes, raises rx_empty 3 cycles after each unload.
  task automatic run_rx(input int n, input logic e, input logic f,
                        output int pushes, output int ulds, output int bad_gap, output int left);
    int rise, nxt, last_push;
    pushes = 0; ulds = 0; bad_gap = 0; left = n;
    rise = -1; nxt = -1; last_push = -100;
    ferr = e; full = f; rx_empty = 1'b0;
    for (int c = 0; c < n * 10 + 20; c++) begin
      @(negedge clk);
      if (push) begin
        pushes++;
        last_push = c;
      end
      if (uld) begin
        ulds++;
        left--;
        if (!e && !f && (c - last_push) != 1) bad_gap++;
        rise = c + 3;
      end
      if (c == rise) begin
        rx_empty = 1'b1;
        if (left > 0) nxt = c + 2;
      end
      if (c == nxt) rx_empty = 1'b0;
      if (left == 0 && rise >= 0 && c >= rise) break;
    end
    @(negedge clk);
    @(negedge clk);
    ferr = 1'b0; full = 1'b0;
  endtask

  int fifo_cnt, pops, lds, bad_lat, overlap, last_pop, drop_at, rise_at;
  int pu, ul, bg, lf, act, ld_c, to_c, busy_at_to, found;
  logic xmit_busy;

  initial begin
    arst_n = 1'b1; srst = 1'b0; tx_en_cfg = 1'b0; rx_en_cfg = 1'b0; clr = 1'b0;
    tx_fifo_empty = 1'b1; tx_empty = 1'b1; rx_empty = 1'b1; ferr = 1'b0; full = 1'b0;
    b_rx_empty = 1'b1; b_ferr = 1'b0; b_full = 1'b0;
    #1 arst_n = 1'b0;
    #2;
    chk("reset_all_out", all_out, 40'h0);
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("idle_tx_en", tx_en, 1'b0);
    tx_en_cfg = 1'b1;
    @(negedge clk);
    chk("tx_en_follows_cfg", tx_en, 1'b1);
    chk("busy_without_data", busy, 1'b0);

    // Two bytes through the transmitter: ack 1 cycle after load, idle again 20 cycles later.
    fifo_cnt = 2; tx_fifo_empty = 1'b0; tx_empty = 1'b1;
    pops = 0; lds = 0; bad_lat = 0; overlap = 0; last_pop = -100; drop_at = -1; rise_at = -1;
    xmit_busy = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (pop) begin
        pops++;
        last_pop = c;
        if (xmit_busy) overlap++;
        fifo_cnt--;
        if (fifo_cnt == 0) tx_fifo_empty = 1'b1;
      end
      if (ld) begin
        lds++;
        if ((c - last_pop) != 2) bad_lat++;
        if (xmit_busy) overlap++;
        drop_at = c + 1; rise_at = c + 21; xmit_busy = 1'b1;
      end
      if (c == drop_at) tx_empty = 1'b0;
      if (c == rise_at) begin
        tx_empty = 1'b1;
        xmit_busy = 1'b0;
      end
    end
    chk("tx_pop_count", pops, 2);
    chk("tx_load_count", lds, 2);
    chk("tx_pop_to_load_2", bad_lat, 0);
    chk("tx_no_overlap", overlap, 0);
    chk("tx_byte_cnt_2", tx_cnt, 8'd2);
    chk("tx_back_idle", busy, 1'b0);

    // Synchronous reset clears counters and registered enables.
    rx_en_cfg = 1'b1;
    @(negedge clk);
    chk("rx_en_follows_cfg", rx_en, 1'b1);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("srst_tx_cnt", tx_cnt, 8'd0);
    chk("srst_rx_en", rx_en, 1'b0);
    chk("srst_tx_en", tx_en, 1'b0);
    @(negedge clk);
    chk("post_srst_rx_en", rx_en, 1'b1);

    run_rx(3, 1'b0, 1'b0, pu, ul, bg, lf);
    chk("rx3_push", pu, 3);
    chk("rx3_unload", ul, 3);
    chk("rx3_push_to_unload_1", bg, 0);
    chk("rx3_done", lf, 0);
    chk("rx3_byte_cnt", rx_cnt, 8'd3);

    run_rx(1, 1'b1, 1'b0, pu, ul, bg, lf);
    chk("ferr_push", pu, 0);
    chk("ferr_unload", ul, 1);
    chk("ferr_cnt", fe_cnt, 8'd1);
    chk("ferr_rx_cnt", rx_cnt, 8'd3);

    run_rx(1, 1'b0, 1'b1, pu, ul, bg, lf);
    chk("drop_push", pu, 0);
    chk("drop_unload", ul, 1);
    chk("drop_cnt", drop_cnt, 8'd1);

    run_rx(256, 1'b1, 1'b0, pu, ul, bg, lf);
    chk("ferr_saturate", fe_cnt, 8'hFF);
    run_rx(252, 1'b0, 1'b0, pu, ul, bg, lf);
    chk("rx_cnt_255", rx_cnt, 8'hFF);
    run_rx(1, 1'b0, 1'b0, pu, ul, bg, lf);
    chk("rx_cnt_wrap", rx_cnt, 8'h00);

    // Back-pressure variant: byte held while full, pushed then unloaded after full clears.
    b_full = 1'b1; b_rx_empty = 1'b0; act = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b_push || b_uld) act++;
    end
    chk("bp_hold_while_full", act, 0);
    b_full = 1'b0;
    @(negedge clk);
    chk("bp_push", b_push, 1'b1);
    chk("bp_no_early_unload", b_uld, 1'b0);
    @(negedge clk);
    chk("bp_unload", b_uld, 1'b1);
    b_rx_empty = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("bp_rx_cnt", b_rx_cnt, 8'd1);
    chk("bp_drop_cnt", b_drop_cnt, 8'd0);

    // Transmitter never acknowledges: timeout after 16 wait cycles.
    tx_en_cfg = 1'b1; tx_fifo_empty = 1'b0; tx_empty = 1'b1;
    ld_c = -1; to_c = -1; busy_at_to = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pop) tx_fifo_empty = 1'b1;
      if (ld) ld_c = c;
      if (tout && to_c < 0) begin
        to_c = c;
        busy_at_to = busy;
      end
    end
    chk("timeout_latency", to_c - ld_c, 17);
    chk("timeout_fsm_idle", busy_at_to, 0);
    chk("timeout_sticky", tout, 1'b1);
    chk("timeout_tx_cnt", tx_cnt, 8'd1);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_timeout", tout, 1'b0);
    chk("clr_all_cnt", {tx_cnt, rx_cnt, drop_cnt, fe_cnt}, 32'h0);

    // Clear on the same cycle as the byte-count increment.
    tx_fifo_empty = 1'b0; found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pop) tx_fifo_empty = 1'b1;
      if (ld) begin
        clr = 1'b1;
        found = 1;
        break;
      end
    end
    chk("clr_inc_load_seen", found, 1);
    @(negedge clk);
    clr = 1'b0;
    chk("clr_beats_inc", tx_cnt, 8'd0);
    chk("in_tx_wait", busy, 1'b1);
    rx_empty = 1'b0;
    @(negedge clk);
    chk("rx_push_before_arst", push, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_immediate", all_out, 40'h0);
    tx_en_cfg = 1'b0; rx_en_cfg = 1'b0; tx_fifo_empty = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    act = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pop || ld || push || uld || busy) act++;
    end
    chk("idle_after_arst", act, 0);
    chk("outputs_after_arst", all_out, 40'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
